// File: rtl/swap_reg_file_pkg.sv
// swap_reg_file_pkg: op codes and sequencer state encoding shared by the swap register file.
package swap_reg_file_pkg;

    localparam logic [1:0] OP_SWAP  = 2'b00;
    localparam logic [1:0] OP_COPY  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/swap_seq_fsm.sv
// swap_seq_fsm: sequencer for swap/copy/clear, holding latched operands and pulse outputs.
module swap_seq_fsm
    import swap_reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  op_valid,
    input  logic [1:0]            op_code,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    output logic                  op_ready,
    output logic                  accept,
    output logic                  busy,
    output logic                  op_done,
    output logic                  op_error,
    output logic                  wr_reject,
    output state_t                state,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [ADDR_WIDTH-1:0] b,
    output logic [1:0]            op
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic                  op_done_q, op_done_d, op_error_q, op_error_d, wr_reject_q, wr_reject_d;

    always_comb begin
        op_ready    = (state_q == S_IDLE) && !we;
        accept      = op_valid && op_ready;
        a_d         = accept ? address_a : a_q;
        b_d         = accept ? address_b : b_q;
        op_d        = accept ? op_code : op_q;
        // only a true two-location swap needs the extra MOVE step
        state_d     = (state_q == S_MOVE)   ? S_COMMIT :
                      (state_q == S_COMMIT) ? S_IDLE :
                      !accept               ? S_IDLE :
                      (op_code == OP_SWAP && address_a != address_b) ? S_MOVE : S_COMMIT;
        op_done_d   = state_q == S_COMMIT;
        op_error_d  = (state_q == S_COMMIT) && (op_q == OP_RSVD);
        wr_reject_d = we && (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            op_done_q   <= 1'b0;
            op_error_q  <= 1'b0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            op_done_q   <= op_done_d;
            op_error_q  <= op_error_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign op_done   = op_done_q;
    assign op_error  = op_error_q;
    assign wr_reject = wr_reject_q;
    assign state     = state_q;
    assign a         = a_q;
    assign b         = b_q;
    assign op        = op_q;

endmodule

// File: rtl/swap_reg_file_ops.sv
// swap_reg_file_ops: multi-read-port register file with sequenced swap, copy and clear.
module swap_reg_file_ops
    import swap_reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int READ_PORTS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            address_w,
    input  logic [DATA_WIDTH-1:0]            data_w,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] address_r,
    output logic [READ_PORTS*DATA_WIDTH-1:0] data_r,
    input  logic                             op_valid,
    input  logic [1:0]                       op_code,
    input  logic [ADDR_WIDTH-1:0]            address_a,
    input  logic [ADDR_WIDTH-1:0]            address_b,
    output logic                             op_ready,
    output logic                             op_done,
    output logic                             op_error,
    output logic                             busy,
    output logic                             wr_reject
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
    logic                  accept;
    state_t                state;
    logic [ADDR_WIDTH-1:0] a, b;
    logic [1:0]            op;

    swap_seq_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .address_a (address_a),
        .address_b (address_b),
        .op_ready  (op_ready),
        .accept    (accept),
        .busy      (busy),
        .op_done   (op_done),
        .op_error  (op_error),
        .wr_reject (wr_reject),
        .state     (state),
        .a         (a),
        .b         (b),
        .op        (op)
    );

    always_comb begin
        mem_d = mem_q;
        tmp_d = accept ? ((op_code == OP_CLEAR) ? '0 : mem_q[address_a]) : tmp_q;
        if (we && state == S_IDLE) mem_d[address_w] = data_w;
        if (state == S_MOVE) mem_d[a] = mem_q[b];
        // tmp already holds 0 for CLEAR, so one commit path serves every real op
        if (state == S_COMMIT && op != OP_RSVD) mem_d[b] = tmp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            tmp_q <= '0;
        end else begin
            mem_q <= mem_d;
            tmp_q <= tmp_d;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        assign data_r[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[address_r[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end

endmodule

// File: tb/tb_swap_reg_file_ops.sv
// tb_swap_reg_file_ops: directed plus randomized checks against an operation-level memory model.
module tb_swap_reg_file_ops;

    logic        clk = 1'b0;
    logic        reset, we, op_valid;
    logic [6:0]  address_w, address_a, address_b;
    logic [7:0]  data_w;
    logic [13:0] address_r;
    logic [15:0] data_r;
    logic [1:0]  op_code;
    logic        op_ready, op_done, op_error, busy, wr_reject;

    logic [7:0] model [128];
    int passed = 0;
    int total  = 0;

    swap_reg_file_ops dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .address_w (address_w),
        .data_w    (data_w),
        .address_r (address_r),
        .data_r    (data_r),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .address_a (address_a),
        .address_b (address_b),
        .op_ready  (op_ready),
        .op_done   (op_done),
        .op_error  (op_error),
        .busy      (busy),
        .wr_reject (wr_reject)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_apply(input logic [1:0] code, input int ia, input int ib);
        logic [7:0] t;
        if (code == 2'b00) begin
            t = model[ia];
            model[ia] = model[ib];
            model[ib] = t;
        end else if (code == 2'b01) model[ib] = model[ia];
        else if (code == 2'b10) model[ib] = 8'h00;
    endtask

    task automatic chk_mem(input string tag, input int a0, input int a1);
        address_r = {7'(a1), 7'(a0)};
        #1;
        chk({tag, "_p0"}, {24'h0, data_r[7:0]}, {24'h0, model[a0]});
        chk({tag, "_p1"}, {24'h0, data_r[15:8]}, {24'h0, model[a1]});
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) chk_mem(tag, i, i + 64);
    endtask

    task automatic do_write(input int addr, input logic [7:0] d);
        we = 1'b1;
        address_w = 7'(addr);
        data_w = d;
        tick();
        we = 1'b0;
        model[addr] = d;
    endtask

    task automatic run_op(input string tag, input logic [1:0] code, input int ia, input int ib, input bit inj);
        int n;
        int exp_lat;
        exp_lat = (code == 2'b00 && ia != ib) ? 3 : 2;
        op_valid = 1'b1;
        op_code = code;
        address_a = 7'(ia);
        address_b = 7'(ib);
        #1;
        chk({tag, "_ready"}, {31'h0, op_ready}, 32'h1);
        tick();
        op_valid = 1'b0;
        model_apply(code, ia, ib);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
        n = 1;
        while (op_done !== 1'b1 && n < 10) begin
            if (inj && n == 1) begin
                we = 1'b1;
                address_w = 7'd30;
                data_w = 8'hAA;
            end
            tick();
            n++;
            if (inj && n == 2) begin
                chk({tag, "_wr_reject"}, {31'h0, wr_reject}, 32'h1);
                we = 1'b0;
            end
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_error"}, {31'h0, op_error}, {31'h0, code == 2'b11});
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        we = 1'b0;
        op_valid = 1'b0;
        address_w = '0;
        data_w = '0;
        address_r = '0;
        op_code = '0;
        address_a = '0;
        address_b = '0;
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, op_done}, 32'h0);
        chk("rst_error", {31'h0, op_error}, 32'h0);
        chk("rst_wr_reject", {31'h0, wr_reject}, 32'h0);
        chk("rst_ready", {31'h0, op_ready}, 32'h1);
        sweep("rst_mem");

        for (int i = 0; i < 10; i++) do_write(20 + i, 8'(20 + i));
        chk_mem("rd_22_28", 22, 28);

        run_op("swap", 2'b00, 22, 28, 1'b0);
        chk_mem("swap_mem", 22, 28);

        op_valid = 1'b1;
        op_code = 2'b00;
        address_a = 7'd22;
        address_b = 7'd28;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (op_done === 1'b1) dones++;
        end
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) model_apply(2'b00, 22, 28);
        chk("b2b_dones", dones, 3);
        chk("b2b_busy", {31'h0, busy}, 32'h0);
        chk_mem("b2b_mem", 22, 28);

        run_op("copy", 2'b01, 25, 40, 1'b0);
        chk_mem("copy_mem", 40, 25);
        run_op("clear", 2'b10, 0, 25, 1'b0);
        chk_mem("clear_mem", 25, 40);

        run_op("swap_wr", 2'b00, 23, 27, 1'b1);
        chk_mem("wr_drop", 30, 23);

        we = 1'b1;
        op_valid = 1'b1;
        op_code = 2'b01;
        address_a = 7'd20;
        address_b = 7'd50;
        address_w = 7'd31;
        data_w = 8'h5C;
        #1;
        chk("we_blocks_ready", {31'h0, op_ready}, 32'h0);
        tick();
        we = 1'b0;
        op_valid = 1'b0;
        model[31] = 8'h5C;
        chk("we_no_accept", {31'h0, busy}, 32'h0);
        chk_mem("we_lands", 31, 50);

        run_op("swap_same", 2'b00, 21, 21, 1'b0);
        chk_mem("swap_same_mem", 21, 22);
        run_op("rsvd", 2'b11, 24, 26, 1'b0);
        sweep("rsvd_mem");

        op_valid = 1'b1;
        op_code = 2'b00;
        address_a = 7'd22;
        address_b = 7'd28;
        tick();
        op_valid = 1'b0;
        chk("abort_busy_before", {31'h0, busy}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, op_done}, 32'h0);
        tick();
        chk("abort_done_later", {31'h0, op_done}, 32'h0);
        sweep("abort_mem");

        for (int i = 0; i < 16; i++) do_write($urandom_range(0, 127), 8'($urandom));
        for (int it = 0; it < 40; it++) begin
            int ra;
            int rb;
            ra = $urandom_range(0, 127);
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 127);
            if ($urandom_range(0, 2) == 0) do_write(ra, 8'($urandom));
            else run_op("rand_op", 2'($urandom_range(0, 3)), ra, rb, 1'b0);
            chk_mem("rand_mem", ra, rb);
        end
        sweep("final_mem");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
